fismos_mem_bus_ctrl: RTL and testbench

// Sequencing controller for the PicoRV32 native memory bus. It sits between the core and its three slaves:
// CPU RAM (cpu_memory), IO register (io_memory) and AXI shared memory (fismos_AXI_shared_memory).
// It decodes each request to exactly one slave and gates that slave's valid, so only one slave ever sees a request.
// It returns a single-cycle ready with registered rdata, and answers unmapped or hung accesses with a bus error.

---
 rtl/fismos_mem_bus_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fismos_mem_bus_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fismos_mem_bus_ctrl.sv
// fismos_mem_bus_ctrl: PicoRV32 native-bus sequencer that routes each request to
// exactly one of RAM / IO / AXI shared memory, returns a registered response,
// and answers unmapped or hung accesses with a bus error.
module fismos_mem_bus_ctrl #(
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] RAM_MASK  = 32'hFFFF_0000,
    parameter logic [31:0] IO_BASE   = 32'h1000_0000,
    parameter logic [31:0] IO_MASK   = 32'hFFFF_FFF0,
    parameter logic [31:0] SHM_BASE  = 32'h2000_0000,
    parameter logic [31:0] SHM_MASK  = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        ram_valid,
    output logic        io_valid,
    output logic        shm_valid,
    input  logic        ram_ready,
    input  logic        io_ready,
    input  logic        shm_ready,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] io_rdata,
    input  logic [31:0] shm_rdata,
    output logic        bus_err,
    output logic [31:0] err_addr,
    output logic [1:0]  err_cause,
    output logic [7:0]  err_count
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] CAUSE_UNMAPPED = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sel_q;          // one-hot {shm, io, ram}
    logic [2:0]       sel_dec;
    logic [CNT_W-1:0] wait_q;
    logic             ram_hit, io_hit, shm_hit;
    logic             sel_ready;
    logic [31:0]      sel_rdata;
    logic             timeout_hit;
    logic             unused_instr;

    // Fetch flag is carried by the core but plays no part in routing
    assign unused_instr = mem_instr;

    // Slave-side address/data are shared wires; only valid is gated
    assign s_addr  = mem_addr;
    assign s_wdata = mem_wdata;
    assign s_wstrb = mem_wstrb;

    // Region decode with RAM > IO > SHM priority on overlap
    always_comb begin
        ram_hit = (mem_addr & RAM_MASK) == RAM_BASE;
        io_hit  = (mem_addr & IO_MASK)  == IO_BASE;
        shm_hit = (mem_addr & SHM_MASK) == SHM_BASE;
        sel_dec = 3'b000;
        if (ram_hit)      sel_dec = 3'b001;
        else if (io_hit)  sel_dec = 3'b010;
        else if (shm_hit) sel_dec = 3'b100;
    end

    // Completion and read data of the selected slave only
    always_comb begin
        sel_ready = |(sel_q & {shm_ready, io_ready, ram_ready});
        sel_rdata = 32'h0;
        unique case (1'b1)
            sel_q[0]: sel_rdata = ram_rdata;
            sel_q[1]: sel_rdata = io_rdata;
            sel_q[2]: sel_rdata = shm_rdata;
            default:  sel_rdata = 32'h0;
        endcase
        timeout_hit = (TIMEOUT != 0) && (wait_q == CNT_W'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_valid) state_d = (sel_dec != 3'b000) ? ACCESS : ERR;
            end
            ACCESS: begin
                if (!mem_valid)       state_d = IDLE;
                else if (sel_ready)   state_d = RESP;
                else if (timeout_hit) state_d = ERR;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state: gated slave valids, response and error strobes
    always_comb begin
        ram_valid = 1'b0;
        io_valid  = 1'b0;
        shm_valid = 1'b0;
        mem_ready = 1'b0;
        bus_err   = 1'b0;
        unique case (state_q)
            ACCESS: begin
                ram_valid = mem_valid & sel_q[0];
                io_valid  = mem_valid & sel_q[1];
                shm_valid = mem_valid & sel_q[2];
            end
            RESP: mem_ready = 1'b1;
            ERR: begin
                mem_ready = 1'b1;
                bus_err   = 1'b1;
            end
            default: ;
        endcase
    end

    // Slave select latch and ACCESS wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q  <= 3'b000;
            wait_q <= '0;
        end else if (state_q == IDLE && mem_valid) begin
            sel_q  <= sel_dec;
            wait_q <= '0;
        end else if (state_q == ACCESS) begin
            wait_q <= wait_q + CNT_W'(1);
        end
    end

    // Response data and error log, loaded on entry to RESP/ERR so they are valid with mem_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rdata <= 32'h0;
            err_addr  <= 32'h0;
            err_cause <= 2'd0;
            err_count <= 8'd0;
        end else if (state_d == ERR) begin
            mem_rdata <= ERR_RDATA;
            err_addr  <= mem_addr;
            err_cause <= (state_q == IDLE) ? CAUSE_UNMAPPED : CAUSE_TIMEOUT;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else if (state_q == ACCESS && state_d == RESP) begin
            mem_rdata <= sel_rdata;
        end
    end

endmodule

// File: tb/tb_fismos_mem_bus_ctrl.sv
// Directed, table-driven bench for fismos_mem_bus_ctrl with hand-written corner sequences.
module tb_fismos_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        ram_valid, io_valid, shm_valid;
    logic        ram_ready, io_ready, shm_ready;
    logic [31:0] ram_rdata, io_rdata, shm_rdata;
    logic        bus_err;
    logic [31:0] err_addr;
    logic [1:0]  err_cause;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_err_addr = 32'h0;

    always #5 clk = ~clk;

    fismos_mem_bus_ctrl dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .ram_valid(ram_valid), .io_valid(io_valid), .shm_valid(shm_valid),
        .ram_ready(ram_ready), .io_ready(io_ready), .shm_ready(shm_ready),
        .ram_rdata(ram_rdata), .io_rdata(io_rdata), .shm_rdata(shm_rdata),
        .bus_err(bus_err), .err_addr(err_addr), .err_cause(err_cause), .err_count(err_count)
    );

    // tgt: 0 = unmapped, 1 = RAM, 2 = IO, 3 = SHM; noise drives every non-target ready high
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          tgt;
        int          dly;
        bit          noise;
        logic [31:0] srdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
        logic [1:0]  exp_cause;
        logic [7:0]  exp_cnt;
        int          exp_vcyc;
    } vec_t;

    function automatic vec_t mk(logic [31:0] a, logic [31:0] wd, logic [3:0] ws, int tgt, int dly,
                                bit noise, logic [31:0] srd, int lat, logic [31:0] erd, bit err,
                                logic [1:0] cause, logic [7:0] cnt, int vcyc);
        vec_t v;
        v.addr = a; v.wdata = wd; v.wstrb = ws; v.tgt = tgt; v.dly = dly; v.noise = noise;
        v.srdata = srd; v.exp_lat = lat; v.exp_rdata = erd; v.exp_err = err;
        v.exp_cause = cause; v.exp_cnt = cnt; v.exp_vcyc = vcyc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one transaction from a negedge, model the target slave, check the response
    task automatic run_vec(input string name, input vec_t v);
        int lat = 0;
        int vcyc = 0;
        bit got = 0;
        bit bad_sel = 0;
        bit bad_multi = 0;
        logic any_v;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wstrb;
        mem_instr = 1'b0;
        mem_valid = 1'b1;
        ram_rdata = (v.tgt == 1) ? v.srdata : 32'h1111_1111;
        io_rdata  = (v.tgt == 2) ? v.srdata : 32'h2222_2222;
        shm_rdata = (v.tgt == 3) ? v.srdata : 32'h3333_3333;
        while (!got && lat < 40) begin
            if ($countones({ram_valid, io_valid, shm_valid}) > 1) bad_multi = 1;
            if ((ram_valid && v.tgt != 1) || (io_valid && v.tgt != 2) || (shm_valid && v.tgt != 3)) bad_sel = 1;
            any_v = ram_valid | io_valid | shm_valid;
            ram_ready = (v.tgt == 1 && ram_valid && vcyc == v.dly) || (v.noise && v.tgt != 1);
            io_ready  = (v.tgt == 2 && io_valid  && vcyc == v.dly) || (v.noise && v.tgt != 2);
            shm_ready = (v.tgt == 3 && shm_valid && vcyc == v.dly) || (v.noise && v.tgt != 3);
            if (any_v) vcyc++;
            idle_cycle();
            lat++;
            if (mem_ready) got = 1;
        end
        if (ram_valid | io_valid | shm_valid) bad_sel = 1;
        if (v.exp_err) model_err_addr = v.addr;
        chk({name, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({name, " rdata"}, mem_rdata, v.exp_rdata);
        chk({name, " bus_err"}, 32'(bus_err), 32'(v.exp_err));
        chk({name, " err_cause"}, 32'(err_cause), 32'(v.exp_cause));
        chk({name, " err_count"}, 32'(err_count), 32'(v.exp_cnt));
        chk({name, " err_addr"}, err_addr, model_err_addr);
        chk({name, " valid_cycles"}, 32'(vcyc), 32'(v.exp_vcyc));
        chk({name, " s_addr"}, s_addr, v.addr);
        chk({name, " valid_exclusive"}, 32'({bad_sel, bad_multi}), 32'(0));
        mem_valid = 1'b0;
        ram_ready = 1'b0;
        io_ready  = 1'b0;
        shm_ready = 1'b0;
        idle_cycle();
        chk({name, " ready_pulse"}, 32'({mem_ready, bus_err}), 32'(0));
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        bit stray;
        reset = 1'b1;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        ram_ready = 1'b0; io_ready = 1'b0; shm_ready = 1'b0;
        ram_rdata = 32'h0; io_rdata = 32'h0; shm_rdata = 32'h0;

        //            addr          wdata  wstrb tgt dly  nz srdata        lat erdata        err cause cnt vcyc
        vecs[0] = mk(32'h0000_0100, 32'h0,  4'h0, 1, 1,    0, 32'h1234_5678, 3,  32'h1234_5678, 0, 2'd0, 8'd0, 2);
        vecs[1] = mk(32'h1000_0000, 32'hA5, 4'hF, 2, 0,    0, 32'h0000_0000, 2,  32'h0000_0000, 0, 2'd0, 8'd0, 1);
        vecs[2] = mk(32'h3000_0000, 32'h0,  4'h0, 0, 0,    1, 32'h0,         1,  32'hDEAD_BEEF, 1, 2'd1, 8'd1, 0);
        vecs[3] = mk(32'h2000_0040, 32'h0,  4'h0, 3, 2,    1, 32'hCAFE_F00D, 4,  32'hCAFE_F00D, 0, 2'd1, 8'd1, 3);
        vecs[4] = mk(32'h1000_000C, 32'h0,  4'h0, 2, 0,    1, 32'h0000_0055, 2,  32'h0000_0055, 0, 2'd1, 8'd1, 1);
        vecs[5] = mk(32'h1000_0010, 32'h77, 4'hF, 0, 0,    0, 32'h0,         1,  32'hDEAD_BEEF, 1, 2'd1, 8'd2, 0);
        vecs[6] = mk(32'h0000_FFFC, 32'h0,  4'h0, 1, 0,    0, 32'hA1B2_C3D4, 2,  32'hA1B2_C3D4, 0, 2'd1, 8'd2, 1);
        vecs[7] = mk(32'h0001_0000, 32'h0,  4'h0, 0, 0,    0, 32'h0,         1,  32'hDEAD_BEEF, 1, 2'd1, 8'd3, 0);
        vecs[8] = mk(32'h2000_FFFC, 32'h0,  4'h0, 3, 1000, 0, 32'h0,         17, 32'hDEAD_BEEF, 1, 2'd2, 8'd4, 16);
        vecs[9] = mk(32'h0000_0200, 32'h0,  4'h0, 1, 3,    1, 32'h0BAD_F00D, 5,  32'h0BAD_F00D, 0, 2'd2, 8'd4, 4);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset ready/err", 32'({mem_ready, bus_err}), 32'(0));
        chk("reset valids", 32'({ram_valid, io_valid, shm_valid}), 32'(0));
        chk("reset rdata", mem_rdata, 32'h0);
        chk("reset err_log", {err_addr[29:0], err_cause}, 32'h0);
        chk("reset err_count", 32'(err_count), 32'(0));
        reset = 1'b0;
        idle_cycle();

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Core drops mem_valid mid-ACCESS: abort silently; late readies in IDLE are ignored
        mem_addr = 32'h2000_0100; mem_wstrb = 4'h0; mem_valid = 1'b1;
        repeat (3) idle_cycle();
        chk("abort shm_valid_before", 32'(shm_valid), 32'(1));
        mem_valid = 1'b0;
        #1;
        chk("abort shm_valid_after", 32'(shm_valid), 32'(0));
        ram_ready = 1'b1; shm_ready = 1'b1;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            if (mem_ready || bus_err || ram_valid || shm_valid) stray = 1;
        end
        ram_ready = 1'b0; shm_ready = 1'b0;
        chk("abort no_response", 32'(stray), 32'(0));
        chk("abort err_count", 32'(err_count), 32'(4));
        run_vec("post_abort", mk(32'h1000_0004, 32'h0, 4'h0, 2, 1, 0, 32'h0000_1234, 3, 32'h0000_1234, 0, 2'd2, 8'd4, 2));

        // 300 unmapped accesses saturate the counter
        for (int i = 0; i < 300; i++) begin
            mem_addr = 32'h3000_0000 + 32'(i * 4); mem_wstrb = 4'hF; mem_valid = 1'b1;
            lat = 0;
            do begin idle_cycle(); lat++; end while (!mem_ready && lat < 10);
            model_err_addr = mem_addr;
            mem_valid = 1'b0;
            idle_cycle();
        end
        chk("sat err_count", 32'(err_count), 32'h0000_00FF);
        run_vec("post_sat", mk(32'h0000_0300, 32'h0, 4'h0, 1, 0, 0, 32'h600D_600D, 2, 32'h600D_600D, 0, 2'd1, 8'hFF, 1));

        // Async reset in the middle of a RAM access
        mem_addr = 32'h0000_0040; mem_wstrb = 4'h0; mem_valid = 1'b1;
        repeat (3) idle_cycle();
        chk("rst_access ram_valid_before", 32'(ram_valid), 32'(1));
        reset = 1'b1;
        #1;
        chk("rst_access valids", 32'({ram_valid, io_valid, shm_valid, mem_ready}), 32'(0));
        chk("rst_access err_count", 32'(err_count), 32'(0));
        chk("rst_access rdata", mem_rdata, 32'h0);
        mem_valid = 1'b0;
        model_err_addr = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        idle_cycle();
        run_vec("post_reset", mk(32'h0000_0044, 32'h0, 4'h0, 1, 0, 0, 32'h5A5A_5A5A, 2, 32'h5A5A_5A5A, 0, 2'd0, 8'd0, 1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
